// File: rtl/zuc_eea3_xor.sv
// zuc_eea3_xor: buffers ZUC keystream words and XORs them with message words
// to produce cipher/plain words. The final word is tail-masked from the
// message bit length latched at msg_start.
// Optional feature macro: ZUC_XOR_DISCARD_EN drops the first keystream word
// accepted after each msg_start.
//
// state | meaning
// IDLE  | waiting for msg_start
// RUN   | moving words; leaves after the last output handshake
// DONE  | msg_done pulse, one cycle
module zuc_eea3_xor #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  input  logic             ks_valid,
  input  logic [31:0]      ks_data,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [31:0]      din_data,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [31:0]      dout_data,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic             msg_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // word counts reach 2^(LEN_W-5); one spare bit also covers the discard word
  localparam int CW = LEN_W - 4;
`ifdef ZUC_XOR_DISCARD_EN
  localparam logic [CW-1:0] KS_EXTRA = CW'(1);
`else
  localparam logic [CW-1:0] KS_EXTRA = CW'(0);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      rem_q;
  logic [CW-1:0]   nwords_q;
  logic [CW-1:0]   word_cnt_q;
  logic [CW-1:0]   ks_cnt_q;
  logic [31:0]     fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]     fifo_cnt;
  logic [LEN_W:0]  len_plus;
  logic [CW-1:0]   nwords_calc;
  logic [CW-1:0]   ks_need;
  logic            run, start_run, fifo_empty, fifo_full;
  logic            ks_acc, push, fire, is_last;
  logic [31:0]     ks_head, mask;

  assign len_plus    = {1'b0, msg_len} + (LEN_W+1)'(31);
  assign nwords_calc = CW'(len_plus >> 5);

  assign run        = (state_q == S_RUN);
  assign start_run  = (state_q == S_IDLE) && msg_start && (msg_len != '0);
  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign ks_need    = nwords_q + KS_EXTRA;

  assign ks_ready = run && !fifo_full && (ks_cnt_q < ks_need);
  assign ks_acc   = ks_valid && ks_ready;

`ifdef ZUC_XOR_DISCARD_EN
  logic discard_q;
  // arm the drop at message start, disarm on the first accepted keystream word
  always_ff @(posedge clk) begin
    if (rst)            discard_q <= 1'b0;
    else if (start_run) discard_q <= 1'b1;
    else if (ks_acc)    discard_q <= 1'b0;
  end
  assign push = ks_acc && !discard_q;
`else
  assign push = ks_acc;
`endif

  assign fire = run && din_valid && !fifo_empty && (!dout_valid || dout_ready)
                && (word_cnt_q < nwords_q);
  assign din_ready = fire;

  assign ks_head = fifo_mem[rd_ptr_q[AW-1:0]];
  assign is_last = (word_cnt_q == nwords_q - CW'(1));
  assign mask    = (is_last && (rem_q != '0)) ? ~(32'hFFFF_FFFF >> rem_q) : 32'hFFFF_FFFF;

  assign busy     = (state_q != S_IDLE);
  assign msg_done = (state_q == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state decode; msg_start only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (msg_start) state_d = (msg_len != '0) ? S_RUN : S_DONE;
      S_RUN:  if (dout_valid && dout_ready && dout_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // latch length-derived values once per message
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      nwords_q <= '0;
    end else if ((state_q == S_IDLE) && msg_start) begin
      rem_q    <= msg_len[4:0];
      nwords_q <= nwords_calc;
    end
  end

  // counters and FIFO pointers, cleared whenever a new message starts
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_cnt_q <= '0;
      ks_cnt_q   <= '0;
    end else begin
      if (push)   wr_ptr_q   <= wr_ptr_q + (AW+1)'(1);
      if (fire)   rd_ptr_q   <= rd_ptr_q + (AW+1)'(1);
      if (fire)   word_cnt_q <= word_cnt_q + CW'(1);
      if (ks_acc) ks_cnt_q   <= ks_cnt_q + CW'(1);
    end
  end

  // keystream storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= ks_data;
  end

  // registered output word; held until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
    end else if (fire) begin
      dout_valid <= 1'b1;
      dout_data  <= (din_data ^ ks_head) & mask;
      dout_last  <= is_last;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zuc_eea3_xor.sv
// Directed bench for zuc_eea3_xor: reset, single word, tail mask, zero
// length, backpressure with keystream gaps, first-word discard behaviour.
module tb_zuc_eea3_xor;

`ifdef ZUC_XOR_DISCARD_EN
  localparam int DISC = 1;
`else
  localparam int DISC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_start;
  logic [15:0] msg_len;
  logic        busy;
  logic        ks_valid;
  logic [31:0] ks_data;
  logic        ks_ready;
  logic        din_valid;
  logic [31:0] din_data;
  logic        din_ready;
  logic        dout_valid;
  logic [31:0] dout_data;
  logic        dout_last;
  logic        dout_ready;
  logic        msg_done;

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] ks_q[$];
  logic [31:0] din_q[$];
  logic [31:0] exp_q[$];

  zuc_eea3_xor #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .msg_len(msg_len), .busy(busy),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_last(dout_last),
    .dout_ready(dout_ready), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    msg_start = 1'b0; msg_len = '0;
    ks_valid = 1'b0; ks_data = '0;
    din_valid = 1'b0; din_data = '0;
    dout_ready = 1'b0;
  endtask

  // called at a falling edge; returns at the falling edge after msg_start is taken
  task automatic start_msg(input logic [15:0] len);
    msg_start = 1'b1; msg_len = len;
    @(negedge clk);
    msg_start = 1'b0;
  endtask

  // stream queued words through the block until msg_done, checking everything
  task automatic run_msg(input int nw, input bit bp, input bit gaps, input string tag);
    int cyc = 0, out_cnt = 0, ks_acc = 0, last_cyc = -10;
    bit stall_prev = 0, done_seen = 0;
    logic [31:0] held = '0, e;
    while (!done_seen && cyc < 3000) begin
      ks_valid   = (ks_q.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
      ks_data    = (ks_q.size() > 0) ? ks_q[0] : 32'h0;
      din_valid  = (din_q.size() > 0);
      din_data   = (din_q.size() > 0) ? din_q[0] : 32'h0;
      dout_ready = bp ? cyc[0] : 1'b1;
      #1;
      if (stall_prev) chk({tag, "_hold"}, dout_data, held);
      if (msg_done) begin
        chk({tag, "_done_lat"}, 32'(cyc - last_cyc), 32'd1);
        done_seen = 1;
      end else begin
        if (dout_valid && dout_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          chk({tag, "_data"}, dout_data, e);
          chk({tag, "_last"}, 32'(dout_last), 32'(out_cnt == nw - 1));
          out_cnt++;
          if (dout_last) last_cyc = cyc;
        end
        if (ks_valid && ks_ready) begin void'(ks_q.pop_front()); ks_acc++; end
        if (din_valid && din_ready) void'(din_q.pop_front());
        stall_prev = dout_valid && !dout_ready;
        held = dout_data;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, "_nwords"}, 32'(out_cnt), 32'(nw));
    chk({tag, "_ks_count"}, 32'(ks_acc), 32'(nw + DISC));
    idle_inputs();
    #1;
    chk({tag, "_done_pulse"}, 32'(msg_done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    ks_q.delete(); din_q.delete(); exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int wait_cyc;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_data", dout_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ks_ready", 32'(ks_ready), 32'd0);
    chk("rst_msg_done", 32'(msg_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // mid-message reset with a word waiting on the output
    start_msg(16'd64);
    ks_valid = 1'b1; ks_data = 32'h0BAD_F00D;
    din_valid = 1'b1; din_data = 32'h1357_9BDF;
    dout_ready = 1'b0;
    wait_cyc = 0;
    while (!dout_valid && wait_cyc < 20) begin @(negedge clk); wait_cyc++; end
    #1;
    chk("midrst_dout_valid_before", 32'(dout_valid), 32'd1);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ks_ready", 32'(ks_ready), 32'd0);
    chk("midrst_msg_done", 32'(msg_done), 32'd0);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);

    // single word, msg_len=32, clean start after reset
    if (DISC != 0) ks_q.push_back(32'hDEAD_BEEF);
    ks_q.push_back(32'hA5A5_A5A5);
    ks_q.push_back(32'h5555_5555);
    din_q.push_back(32'h0F0F_0F0F);
    exp_q.push_back(32'hAAAA_AAAA);
    start_msg(16'd32);
    run_msg(1, 0, 0, "single");

    // tail mask, msg_len=40 -> rem 8
    if (DISC != 0) ks_q.push_back(32'hDEAD_BEEF);
    ks_q.push_back(32'h0);
    ks_q.push_back(32'h0);
    ks_q.push_back(32'hFFFF_FFFF);
    din_q.push_back(32'h1122_3344);
    din_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h1122_3344);
    exp_q.push_back(32'hFF00_0000);
    start_msg(16'd40);
    run_msg(2, 0, 0, "tail");

    // zero length: straight to DONE, nothing moves
    ks_valid = 1'b1; ks_data = 32'h1111_1111;
    din_valid = 1'b1; din_data = 32'h2222_2222;
    dout_ready = 1'b1;
    start_msg(16'd0);
    #1;
    chk("zero_msg_done", 32'(msg_done), 32'd1);
    chk("zero_ks_ready", 32'(ks_ready), 32'd0);
    chk("zero_din_ready", 32'(din_ready), 32'd0);
    chk("zero_dout_valid", 32'(dout_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("zero_msg_done_clear", 32'(msg_done), 32'd0);
    chk("zero_dout_valid_after", 32'(dout_valid), 32'd0);
    chk("zero_ks_ready_after", 32'(ks_ready), 32'd0);
    idle_inputs();
    @(negedge clk);

    // backpressure, msg_len=256, dout_ready toggling, keystream gaps
    if (DISC != 0) ks_q.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] k, d;
      k = 32'(i + 1) * 32'h9E37_79B9;
      d = 32'h0101_0101 * 32'(i) ^ 32'hC0DE_0000;
      ks_q.push_back(k);
      din_q.push_back(d);
      exp_q.push_back(k ^ d);
    end
    ks_q.push_back(32'hFFFF_0000);
    ks_q.push_back(32'h0000_FFFF);
    start_msg(16'd256);
    run_msg(8, 1, 1, "bp");

    // first keystream word dropped only when the discard feature is built in
    ks_q.push_back(32'hDEAD_BEEF);
    ks_q.push_back(32'h1234_5678);
    din_q.push_back(32'h0);
    exp_q.push_back((DISC != 0) ? 32'h1234_5678 : 32'hDEAD_BEEF);
    start_msg(16'd32);
    run_msg(1, 0, 0, "discard");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
